// File: rtl/data_mem_copy.sv
// data_mem_copy: block-copy engine and arbiter for the single-port data RAM.
// Ports: clk/rst; start,src,dst,len copy request; busy,done status;
//   cpu_addr/cpu_din/cpu_we/cpu_dout CPU side; mem_addr/mem_din/mem_we/mem_dout RAM side.
module data_mem_copy #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW-1:0] len,
   output logic          busy,
   output logic          done,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   input  logic          cpu_we,
   output logic [7:0]    cpu_dout,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_we,
   input  logic [7:0]    mem_dout
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] ZERO = '0;

   logic [1:0]    state;
   logic [AW-1:0] src_ptr;
   logic [AW-1:0] dst_ptr;
   logic [AW-1:0] count;
   logic [7:0]    data_buf;

   assign busy     = (state == READ) || (state == WRITE);
   assign done     = (state == DONE);
   assign cpu_dout = mem_dout;

   // CPU owns the port in IDLE and DONE; the engine owns it otherwise,
   // which also blocks any CPU write while a copy is running.
   always_comb begin
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
      mem_we   = cpu_we;
      unique case (state)
         READ: begin
            mem_addr = src_ptr;
            mem_din  = data_buf;
            mem_we   = 1'b0;
         end
         WRITE: begin
            mem_addr = dst_ptr;
            mem_din  = data_buf;
            mem_we   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         src_ptr  <= '0;
         dst_ptr  <= '0;
         count    <= '0;
         data_buf <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  src_ptr <= src;
                  dst_ptr <= dst;
                  count   <= len;
                  state   <= (len == ZERO) ? DONE : READ;
               end
            end
            READ: begin
               data_buf <= mem_dout;
               src_ptr  <= src_ptr + ONE;
               state    <= WRITE;
            end
            WRITE: begin
               dst_ptr <= dst_ptr + ONE;
               count   <= count - ONE;
               state   <= (count == ONE) ? DONE : READ;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_copy.sv
// tb_data_mem_copy: drives data_mem_copy with a bench-side RAM and checks
// it cycle by cycle against a transaction-level copy model.
module tb_data_mem_copy;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] src = '0;
   logic [7:0] dst = '0;
   logic [7:0] len = '0;
   logic       busy;
   logic       done;
   logic [7:0] cpu_addr = '0;
   logic [7:0] cpu_din = '0;
   logic       cpu_we = 1'b0;
   logic [7:0] cpu_dout;
   logic [7:0] mem_addr;
   logic [7:0] mem_din;
   logic       mem_we;
   logic [7:0] mem_dout;

   int vectors = 0;
   int miscompares = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int we_cnt = 0;

   data_mem_copy #(.AW(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_we(cpu_we), .cpu_dout(cpu_dout),
      .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_we(mem_we), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // RAM: combinational read, synchronous write
   bit [7:0] ram [256];
   assign mem_dout = ram[mem_addr];
   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_din;

   // Model: a copy of n bytes occupies 2n+1 cycles after the accepting edge;
   // byte j lands on the (2j)th edge, CPU writes land only when not copying.
   bit [7:0] ref_mem [256];
   bit       m_active = 1'b0;
   int       m_t = 0;
   int       m_n = 0;
   bit [7:0] m_src = '0;
   bit [7:0] m_dst = '0;
   wire exp_busy = m_active && (m_t < 2 * m_n);
   wire exp_done = m_active && (m_t == 2 * m_n);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_t <= 0;
      end else begin
         if (exp_busy && m_t[0])
            ref_mem[8'(m_dst + 8'(m_t / 2))] <= ref_mem[8'(m_src + 8'(m_t / 2))];
         else if (!exp_busy && cpu_we)
            ref_mem[cpu_addr] <= cpu_din;
         if (!m_active) begin
            if (start) begin
               m_active <= 1'b1;
               m_t <= 0;
               m_n <= int'(len);
               m_src <= src;
               m_dst <= dst;
            end
         end else if (m_t == 2 * m_n) begin
            m_active <= 1'b0;
         end else begin
            m_t <= m_t + 1;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (mem_we) we_cnt++;
         chk("busy", int'(busy), int'(exp_busy));
         chk("done", int'(done), int'(exp_done));
         if (exp_busy) begin
            chk("mem_we", int'(mem_we), int'(m_t[0]));
            if (m_t[0]) begin
               chk("wr_addr", int'(mem_addr), int'(8'(m_dst + 8'(m_t / 2))));
               chk("wr_data", int'(mem_din), int'(ref_mem[8'(m_src + 8'(m_t / 2))]));
            end else begin
               chk("rd_addr", int'(mem_addr), int'(8'(m_src + 8'(m_t / 2))));
            end
         end else begin
            chk("mem_we", int'(mem_we), int'(cpu_we));
            chk("mem_addr", int'(mem_addr), int'(cpu_addr));
            chk("cpu_dout", int'(cpu_dout), int'(ref_mem[cpu_addr]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      cpu_addr = a;
      cpu_din = d;
      cpu_we = 1'b1;
      tick();
      cpu_we = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 600; i++) begin
         if (!m_active) break;
         tick();
      end
      chk("timeout", int'(m_active), 0);
   endtask

   task automatic copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
      busy_cnt = 0;
      done_cnt = 0;
      we_cnt = 0;
      src = s;
      dst = d;
      len = n;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();
   endtask

   initial begin
      #2;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_we", int'(mem_we), 0);
      cpu_addr = 8'h5A;
      #1;
      chk("rst_addr", int'(mem_addr), 32'h5A);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // basic copy
      cpu_write(8'h10, 8'hA1);
      cpu_write(8'h11, 8'hA2);
      cpu_write(8'h12, 8'hA3);
      cpu_write(8'h13, 8'hA4);
      copy(8'h10, 8'h80, 8'd4);
      chk("t1_busy_cycles", busy_cnt, 8);
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_writes", we_cnt, 4);
      chk("t1_d0", int'(ram[8'h80]), 32'hA1);
      chk("t1_d1", int'(ram[8'h81]), 32'hA2);
      chk("t1_d2", int'(ram[8'h82]), 32'hA3);
      chk("t1_d3", int'(ram[8'h83]), 32'hA4);
      chk("t1_src", int'(ram[8'h10]), 32'hA1);

      // zero length
      copy(8'h10, 8'h60, 8'd0);
      chk("t2_busy_cycles", busy_cnt, 0);
      chk("t2_done_pulses", done_cnt, 1);
      chk("t2_writes", we_cnt, 0);
      chk("t2_dst", int'(ram[8'h60]), 0);

      // source wraps past 0xFF
      cpu_write(8'hFE, 8'h11);
      cpu_write(8'hFF, 8'h22);
      cpu_write(8'h00, 8'h33);
      cpu_write(8'h01, 8'h44);
      copy(8'hFE, 8'h40, 8'd4);
      chk("t3_d0", int'(ram[8'h40]), 32'h11);
      chk("t3_d1", int'(ram[8'h41]), 32'h22);
      chk("t3_d2", int'(ram[8'h42]), 32'h33);
      chk("t3_d3", int'(ram[8'h43]), 32'h44);

      // forward overlap replicates
      cpu_write(8'h20, 8'h55);
      copy(8'h20, 8'h21, 8'd3);
      chk("t4_d0", int'(ram[8'h21]), 32'h55);
      chk("t4_d1", int'(ram[8'h22]), 32'h55);
      chk("t4_d2", int'(ram[8'h23]), 32'h55);

      // CPU write and second start ignored while busy
      cpu_write(8'h90, 8'h77);
      busy_cnt = 0;
      done_cnt = 0;
      src = 8'h10;
      dst = 8'h84;
      len = 8'd2;
      start = 1'b1;
      tick();
      src = 8'h00;
      dst = 8'hA0;
      len = 8'd1;
      cpu_addr = 8'h90;
      cpu_din = 8'hEE;
      cpu_we = 1'b1;
      repeat (3) tick();
      cpu_we = 1'b0;
      start = 1'b0;
      wait_idle();
      repeat (3) tick();
      chk("t5_busy_cycles", busy_cnt, 4);
      chk("t5_done_pulses", done_cnt, 1);
      chk("t5_blocked", int'(ram[8'h90]), 32'h77);
      chk("t5_no_second", int'(ram[8'hA0]), 0);
      chk("t5_copy", int'(ram[8'h85]), 32'hA2);
      cpu_write(8'h90, 8'hEE);
      chk("t5_post_wr", int'(ram[8'h90]), 32'hEE);

      // reset mid-copy after the second write
      for (int i = 0; i < 6; i++) cpu_write(8'(8'h30 + i), 8'(i + 1));
      busy_cnt = 0;
      done_cnt = 0;
      src = 8'h30;
      dst = 8'hC0;
      len = 8'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("t6_busy_pre", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("t6_busy_async", int'(busy), 0);
      chk("t6_we_async", int'(mem_we), 0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("t6_done_pulses", done_cnt, 0);
      chk("t6_d0", int'(ram[8'hC0]), 32'h01);
      chk("t6_d1", int'(ram[8'hC1]), 32'h02);
      chk("t6_d2", int'(ram[8'hC2]), 0);
      cpu_write(8'hC5, 8'h99);
      cpu_addr = 8'hC5;
      #1;
      chk("t6_post_rd", int'(cpu_dout), 32'h99);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_mem_copy.md
# data_mem_copy

Block-copy engine and port arbiter sitting directly upstream of the 8-bit data RAM. It owns the RAM's single address/data/write-enable port, passing CPU accesses through when idle and, on a start request, moving a run of bytes from a source to a destination region. It relies on the RAM's combinational read and synchronous write.

## Interface

- AW, 8, address width; RAM holds 2^AW bytes

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  copy request, sampled on rising clk
- src  in  AW  source start address, latched on accepted start
- dst  in  AW  destination start address, latched on accepted start
- len  in  AW  byte count, latched on accepted start; 0 = no-op
- busy  out  1  engine owns RAM port (READ or WRITE state)
- done  out  1  one-cycle completion pulse
- cpu_addr  in  AW  CPU address
- cpu_din  in  8  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_dout  out  8  CPU read data; always equals mem_dout
- mem_addr  out  AW  to RAM addr
- mem_din  out  8  to RAM din
- mem_we  out  1  to RAM we
- mem_dout  in  8  from RAM dout (combinational)

## Operation

- States: IDLE, READ, WRITE, DONE. Registers: state, src_ptr, dst_ptr, count (AW bits), buf (8 bits).
- IDLE: mem_addr=cpu_addr, mem_din=cpu_din, mem_we=cpu_we. start=1 latches src/dst/len; len≠0 → READ, len=0 → DONE.
- READ: mem_addr=src_ptr, mem_we=0; at edge buf<=mem_dout, src_ptr<=src_ptr+1 → WRITE.
- WRITE: mem_addr=dst_ptr, mem_din=buf, mem_we=1; at edge dst_ptr<=dst_ptr+1, count<=count-1; count==1 → DONE, else → READ.
- DONE: done=1, ports pass through CPU as in IDLE; unconditionally → IDLE.
- start ignored in READ, WRITE, DONE (not queued).
- cpu_we ignored while busy (no CPU write reaches RAM); cpu_dout then shows the engine's current read, meaningless to CPU.
- Pointers wrap modulo 2^AW (0xFF+1 = 0x00 at AW=8).
- Overlap: strictly forward byte-by-byte; each read follows the previous write, so dst=src+1 replicates mem[src] across the run. Defined, not an error.
- len max 2^AW−1 (AW-bit field).

## Timing

- Reset (async, immediate): state=IDLE, busy=0, done=0, buf=0, pointers/count=0; mem_* follow cpu_* combinationally; mem_we=cpu_we.
- Reset mid-copy: busy and engine mem_we drop without waiting for clk; bytes already written stay; no further writes; no done pulse.
- Start accepted at edge E0 with len=N>0: busy=1 from E0 to E(2N); writes commit at edges E2, E4, …, E(2N); done=1 between E(2N) and E(2N+1); IDLE after E(2N+1); next start accepted at E(2N+1).
- len=0: done=1 between E0 and E1, busy never asserted, no mem_we.
- busy and done never high together.
- Throughput: 2 cycles/byte; total occupancy 2N+1 cycles.

## Test plan

- Preload mem[0x10..0x13]=A1,A2,A3,A4; start src=0x10 dst=0x80 len=4 → mem[0x80..0x83]=A1..A4, busy high 8 cycles, single done pulse on 9th, source unchanged.
- start len=0 → done high exactly 1 cycle after start edge, busy never high, mem_we never asserted, RAM unchanged.
- Preload mem[0xFE,0xFF,0x00,0x01]=11,22,33,44; start src=0xFE dst=0x40 len=4 → mem[0x40..0x43]=11,22,33,44.
- mem[0x20]=0x55; start src=0x20 dst=0x21 len=3 → mem[0x21..0x23]=55,55,55.
- During busy assert cpu_we=1 cpu_addr=0x90 cpu_din=0xEE and a second start → mem[0x90] unchanged, no second copy; after done, CPU write to 0x90 lands 0xEE next edge.
- len=6 copy, assert rst after second write edge → busy=0 immediately, only first two destination bytes changed, no done; post-reset CPU read/write works.
